// File: rtl/tc_program_loader.sv
// tc_program_loader: loads a length-prefixed, checksummed byte stream into program memory.
module tc_program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [7:0] addr, acc;
  logic [8:0] cnt, n;
  logic idle_like;
  assign in_ready  = state == LEN || state == DATA || state == CSUM;
  assign busy      = in_ready;
  assign done      = state == DONE;
  assign error     = state == ERR;
  assign idle_like = state == IDLE || state == DONE || state == ERR;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: state_nx = start ? LEN : state;
      LEN:             state_nx = in_valid ? DATA : LEN;
      DATA:            state_nx = in_valid && cnt + 9'd1 == n ? CSUM : DATA;
      CSUM:            state_nx = !in_valid ? CSUM : in_data == acc ? DONE : ERR;
      default:         state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // A length byte of zero encodes a full 256-byte payload.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr    <= 8'h00;
      acc     <= 8'h00;
      cnt     <= 9'd0;
      n       <= 9'd0;
      wr_en   <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (idle_like && start) begin
        addr <= BASE_ADDR;
        cnt  <= 9'd0;
        acc  <= 8'h00;
      end
      if (state == LEN && in_valid) n <= in_data == 8'h00 ? 9'd256 : {1'b0, in_data};
      if (state == DATA && in_valid) begin
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= in_data;
        addr    <= addr + 8'd1;
        cnt     <= cnt + 9'd1;
        acc     <= acc + in_data;
      end
    end
endmodule

// File: tb/tb_tc_program_loader.sv
// tb_tc_program_loader: stream-level model checks two loaders (base 00 and FE) every cycle.
module tb_tc_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic rdy [2], wen [2], bsy [2], dn [2], er [2];
  logic [7:0] wa [2], wd [2];
  int tests = 0, fails = 0, cnum = 0;
  logic [31:0] log0 [$], log1 [$];
  logic [7:0] s [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    tc_program_loader #(.BASE_ADDR(g == 0 ? 8'h00 : 8'hFE)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[g]), .wr_en(wen[g]), .wr_addr(wa[g]), .wr_data(wd[g]),
      .busy(bsy[g]), .done(dn[g]), .error(er[g]));
  end
  function automatic logic [7:0] base(int i);
    return i == 0 ? 8'h00 : 8'hFE;
  endfunction
  // Model: a load accepts one length byte, N payload bytes, one checksum byte.
  logic m_ready = 0, m_done = 0, m_err = 0, m_wr = 0;
  int m_left = 0;
  logic [7:0] m_sum = 0, m_wd = 0;
  logic [7:0] m_addr [2] = '{8'h00, 8'h00};
  logic [7:0] m_wa [2] = '{8'h00, 8'h00};
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready <= 0; m_done <= 0; m_err <= 0; m_wr <= 0; m_left <= 0;
      m_sum <= 0; m_wd <= 0;
      for (int i = 0; i < 2; i++) begin m_addr[i] <= 0; m_wa[i] <= 0; end
    end else begin
      cnum <= cnum + 1;
      m_wr <= 0;
      if (!m_ready) begin
        if (start) begin
          m_ready <= 1; m_done <= 0; m_err <= 0; m_left <= -1; m_sum <= 0;
          for (int i = 0; i < 2; i++) m_addr[i] <= base(i);
        end
      end else if (in_valid) begin
        if (m_left < 0) m_left <= in_data == 0 ? 256 : int'(in_data);
        else if (m_left > 0) begin
          m_wr <= 1; m_wd <= in_data; m_sum <= m_sum + in_data; m_left <= m_left - 1;
          for (int i = 0; i < 2; i++) begin m_wa[i] <= m_addr[i]; m_addr[i] <= m_addr[i] + 8'd1; end
        end else begin
          m_ready <= 0; m_done <= in_data == m_sum; m_err <= in_data != m_sum;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(m_ready));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_ready));
      chk($sformatf("done%0d", i), 32'(dn[i]), 32'(m_done));
      chk($sformatf("error%0d", i), 32'(er[i]), 32'(m_err));
      chk($sformatf("wr_en%0d", i), 32'(wen[i]), 32'(m_wr));
      chk($sformatf("wr_addr%0d", i), 32'(wa[i]), 32'(m_wa[i]));
      chk($sformatf("wr_data%0d", i), 32'(wd[i]), 32'(m_wd));
    end
    if (wen[0]) log0.push_back({cnum[15:0], wa[0], wd[0]});
    if (wen[1]) log1.push_back({cnum[15:0], wa[1], wd[1]});
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1; cyc; start = 0;
  endtask
  task automatic send(input logic [7:0] b [$], input bit rnd);
    foreach (b[k]) begin
      if (rnd) while ($urandom_range(0, 1) == 1) begin in_valid = 0; cyc; end
      in_valid = 1; in_data = b[k]; cyc;
    end
    in_valid = 0;
  endtask
  task automatic load(input logic [7:0] b [$], input bit rnd);
    log0.delete(); log1.delete();
    pulse_start;
    send(b, rnd);
    cyc; cyc;
  endtask
  task automatic zero_outputs(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_outs%0d", tag, i), {rdy[i], wen[i], bsy[i], dn[i], er[i], wa[i], wd[i]}, 32'h0);
  endtask
  initial begin
    int sz, hit;
    logic [255:0] seen;
    repeat (2) cyc;
    zero_outputs("reset");
    rst = 1; cyc;
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    load(s, 0);
    chk("ok_count", log0.size(), 3);
    chk("ok_w0", log0[0][15:0], 16'h0011);
    chk("ok_w1", log0[1][15:0], 16'h0122);
    chk("ok_w2", log0[2][15:0], 16'h0233);
    chk("ok_consecutive", log0[2][31:16] - log0[0][31:16], 2);
    chk("ok_done", {dn[0], er[0]}, 2'b10);
    in_valid = 1; in_data = 8'h55; repeat (3) cyc; in_valid = 0;
    chk("done_no_xfer", log0.size(), 3);
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    load(s, 0);
    chk("bad_count", log0.size(), 3);
    chk("bad_error", {dn[0], er[0]}, 2'b01);
    pulse_start;
    chk("restart_busy", {bsy[0], dn[0], er[0]}, 3'b100);
    s = '{8'h01, 8'h05, 8'h05};
    send(s, 0); cyc; cyc;
    chk("restart_done", dn[0], 1);
    s = '{8'h02, 8'hAA, 8'hBB, 8'h65};
    load(s, 0);
    chk("fe_w0", log1[0][15:0], 16'hFEAA);
    chk("fe_w1", log1[1][15:0], 16'hFFBB);
    chk("fe_done", dn[1], 1);
    s = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    load(s, 0);
    chk("fe_wrap", log1[2][15:0], 16'h00CC);
    chk("fe_wrap_done", dn[1], 1);
    s.delete(); s.push_back(8'h00);
    repeat (256) s.push_back(8'h01);
    s.push_back(8'h00);
    load(s, 0);
    seen = '0;
    foreach (log0[k]) seen[log0[k][15:8]] = 1'b1;
    hit = $countones(seen);
    chk("full_count", log0.size(), 256);
    chk("full_cover", hit, 256);
    chk("full_done", dn[0], 1);
    s = '{8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    load(s, 1);
    chk("rnd_count", log0.size(), 4);
    chk("rnd_w0", log0[0][15:0], 16'h0010);
    chk("rnd_w1", log0[1][15:0], 16'h0120);
    chk("rnd_w2", log0[2][15:0], 16'h0230);
    chk("rnd_w3", log0[3][15:0], 16'h0340);
    chk("rnd_done", dn[0], 1);
    log0.delete(); log1.delete();
    pulse_start;
    s = '{8'h05, 8'h01, 8'h02};
    send(s, 0);
    #2 rst = 0;
    #1 zero_outputs("async");
    sz = log0.size();
    repeat (2) cyc;
    rst = 1;
    in_valid = 1; in_data = 8'h07; repeat (3) cyc; in_valid = 0;
    chk("post_reset_nowr", log0.size(), sz);
    chk("post_reset_idle", bsy[0], 0);
    pulse_start;
    start = 1; cyc; start = 0;
    chk("start_ignored", {bsy[0], dn[0]}, 2'b10);
    s = '{8'h01, 8'h09, 8'h09};
    send(s, 0); cyc; cyc;
    chk("after_reset_w", log0[log0.size() - 1][15:0], 16'h0009);
    chk("after_reset_done", dn[0], 1);
    cyc;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
